// File: rtl/sea_pkg.sv
// Shared definitions for the SEA Feistel core: S-box, mode encoding, FSM states
// and width-generic rotate helpers.
package sea_pkg;

  // Widest half-block the rotate helpers can handle.
  localparam int MAX_W = 256;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [2:0] SBOX [8] = '{3'd6, 3'd4, 3'd7, 3'd1, 3'd0, 3'd3, 3'd5, 3'd2};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Both helpers rotate the low w bits of x; bits above w must be zero, 0 <= n < w.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int w, input int n);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    return ((x << n) | (x >> (w - n))) & mask;
  endfunction

  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x, input int w, input int n);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    return ((x >> n) | (x << (w - n))) & mask;
  endfunction

endpackage

// File: rtl/sea_round.sv
// One combinational SEA Feistel round; mode selects the encrypt round or its
// exact inverse.
module sea_round
  import sea_pkg::*;
#(
  parameter int HALF_W = 48
) (
  input  logic [HALF_W-1:0] l,
  input  logic [HALF_W-1:0] r,
  input  logic [HALF_W-1:0] k,
  input  logic              mode,
  output logic [HALF_W-1:0] l_n,
  output logic [HALF_W-1:0] r_n
);

  localparam int NG = HALF_W / 3;

  logic [HALF_W-1:0] w_f_in;
  logic [HALF_W-1:0] w_s;
  logic [HALF_W-1:0] w_f;
  logic [HALF_W-1:0] w_enc_l;
  logic [HALF_W-1:0] w_dec_r;

  // Encrypt feeds F from L, decrypt from R (which holds the previous L).
  assign w_f_in = ((mode == MODE_ENC) ? l : r) ^ k;

  for (genvar g = 0; g < NG; g++) begin : g_sbox
    assign w_s[3*g +: 3] = SBOX[w_f_in[3*g +: 3]];
  end

  assign w_f     = HALF_W'(rotl(MAX_W'(w_s), HALF_W, 1));
  assign w_enc_l = HALF_W'(rotl(MAX_W'(r ^ w_f), HALF_W, 8));
  assign w_dec_r = HALF_W'(rotr(MAX_W'(l), HALF_W, 8)) ^ w_f;

  assign l_n = (mode == MODE_ENC) ? w_enc_l : r;
  assign r_n = (mode == MODE_ENC) ? l : w_dec_r;

endmodule

// File: rtl/sea_iter_core.sv
// Iterative SEA encrypt/decrypt core: one round per clock with an on-the-fly
// key schedule, valid/ready on both block input and result output.
module sea_iter_core
  import sea_pkg::*;
#(
  parameter int HALF_W = 48,
  parameter int ROUNDS = 16,
  parameter int KROT   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [HALF_W-1:0] in_l,
  input  logic [HALF_W-1:0] in_r,
  input  logic [HALF_W-1:0] in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HALF_W-1:0] out_l,
  output logic [HALF_W-1:0] out_r,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int            CW      = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST    = CW'(ROUNDS - 1);
  localparam int            DEC_ROT = (KROT * (ROUNDS - 1)) % HALF_W;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE, and the
  // result holds stable until out_ready completes the transfer.
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [HALF_W-1:0] r_l;
  logic [HALF_W-1:0] r_r;
  logic [HALF_W-1:0] r_key;
  logic              r_mode;
  logic [HALF_W-1:0] r_out_l;
  logic [HALF_W-1:0] r_out_r;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [HALF_W-1:0] w_l_n;
  logic [HALF_W-1:0] w_r_n;
  logic [HALF_W-1:0] w_key_l;
  logic [HALF_W-1:0] w_key_r;
  logic [HALF_W-1:0] w_dec_key0;

  sea_round #(.HALF_W(HALF_W)) u_round (
    .l   (r_l),
    .r   (r_r),
    .k   (r_key),
    .mode(r_mode),
    .l_n (w_l_n),
    .r_n (w_r_n)
  );

  // Decrypt starts from the last encrypt round key and walks the schedule back.
  assign w_key_l    = HALF_W'(rotl(MAX_W'(r_key), HALF_W, KROT));
  assign w_key_r    = HALF_W'(rotr(MAX_W'(r_key), HALF_W, KROT));
  assign w_dec_key0 = HALF_W'(rotl(MAX_W'(in_key), HALF_W, DEC_ROT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_l         <= '0;
      r_r         <= '0;
      r_key       <= '0;
      r_mode      <= MODE_ENC;
      r_out_l     <= '0;
      r_out_r     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_l        <= in_l;
            r_r        <= in_r;
            r_key      <= (in_mode == MODE_DEC) ? w_dec_key0 : in_key;
            r_mode     <= in_mode;
            r_cnt      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_l   <= w_l_n;
          r_r   <= w_r_n;
          r_key <= (r_mode == MODE_ENC) ? w_key_l : w_key_r;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state     <= DONE;
            r_out_l     <= w_l_n;
            r_out_r     <= w_r_n;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_l     = r_out_l;
  assign out_r     = r_out_r;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sea_iter_core.sv
// Directed bench for sea_iter_core: vector table against a bench reference
// model, plus hand sequences for hold, reset abort, streaming and ROUNDS=1.
module tb_sea_iter_core;

  localparam int W = 48;
  localparam int R = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst_n;
  logic         in_valid, in_mode, out_ready;
  logic [W-1:0] in_l, in_r, in_key;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] out_l, out_r;
  logic [1:0]   dbg_state;

  logic         in1_valid, in1_ready, out1_valid, busy1;
  logic [W-1:0] out1_l, out1_r;
  logic [1:0]   dbg1_state;

  sea_iter_core #(.HALF_W(W), .ROUNDS(R), .KROT(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_l(in_l), .in_r(in_r), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_r(out_r),
    .busy(busy), .dbg_state(dbg_state)
  );

  sea_iter_core #(.HALF_W(W), .ROUNDS(1), .KROT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in1_valid), .in_ready(in1_ready),
    .in_mode(in_mode), .in_l(in_l), .in_r(in_r), .in_key(in_key),
    .out_valid(out1_valid), .out_ready(out_ready), .out_l(out1_l), .out_r(out1_r),
    .busy(busy1), .dbg_state(dbg1_state)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [95:0] exp_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model, written from the cipher definition rather than the datapath.
  function automatic logic [47:0] m_rotl(input logic [47:0] x, input int n);
    logic [47:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[46:0], y[47]};
    return y;
  endfunction

  function automatic logic [47:0] m_f(input logic [47:0] x);
    logic [47:0] s;
    logic [2:0]  g3, o3;
    s = '0;
    for (int g = 0; g < 16; g++) begin
      g3 = x[3*g +: 3];
      case (g3)
        3'd0: o3 = 3'd6;
        3'd1: o3 = 3'd4;
        3'd2: o3 = 3'd7;
        3'd3: o3 = 3'd1;
        3'd4: o3 = 3'd0;
        3'd5: o3 = 3'd3;
        3'd6: o3 = 3'd5;
        default: o3 = 3'd2;
      endcase
      s[3*g +: 3] = o3;
    end
    return m_rotl(s, 1);
  endfunction

  function automatic logic [95:0] model(input logic mode, input logic [47:0] l0,
                                        input logic [47:0] r0, input logic [47:0] key,
                                        input int rounds);
    logic [47:0] l, r, k, t;
    l = l0;
    r = r0;
    for (int i = 0; i < rounds; i++) begin
      if (mode == 1'b0) begin
        k = m_rotl(key, (3 * i) % 48);
        t = m_rotl(r ^ m_f(l ^ k), 8);
        r = l;
        l = t;
      end else begin
        k = m_rotl(key, (3 * (rounds - 1 - i)) % 48);
        t = m_rotl(l, 40) ^ m_f(r ^ k);
        l = r;
        r = t;
      end
    end
    return {l, r};
  endfunction

  // Driver: present a block and return at #1 after the accepting edge.
  task automatic send(input logic mode, input logic [W-1:0] l, input logic [W-1:0] r,
                      input logic [W-1:0] key);
    int b;
    b = 0;
    in_mode = mode; in_l = l; in_r = r; in_key = key; in_valid = 1'b1;
    while (!in_ready && b < 100) begin @(posedge clk); #1; b++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic collect(input string name, output logic [95:0] res);
    logic [95:0] exp;
    int lat;
    wait_out(lat);
    exp = exp_q.pop_front();
    res = {out_l, out_r};
    chk({name, " latency"}, 96'(lat), 96'(R));
    chk({name, " data"}, res, exp);
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  typedef struct {
    logic         mode;
    logic [W-1:0] l, r, key;
    logic [95:0]  exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] tl, tr, tk;
    logic [95:0]  res, snap;
    int lat, bad, bnd, t_prev, t_now;

    vecs[0] = '{1'b0, 48'h0, 48'h0, 48'h0, 96'h0};
    vecs[1] = '{1'b0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 96'h0};
    vecs[2] = '{1'b0, 48'h0123_4567_89AB, 48'hCDEF_0011_2233, 48'h1357_9BDF_2468, 96'h0};
    vecs[3] = '{1'b1, 48'hDEAD_BEEF_CAFE, 48'h0BAD_F00D_1234, 48'hA5A5_5A5A_C3C3, 96'h0};
    vecs[4] = '{1'b0, 48'h8000_0000_0001, 48'h0000_0000_0000, 48'h0000_0000_0001, 96'h0};
    vecs[5] = '{1'b1, 48'h0000_0000_0000, 48'h0000_0000_0000, 48'h8421_8421_8421, 96'h0};
    for (int i = 0; i < 6; i++)
      vecs[i].exp = model(vecs[i].mode, vecs[i].l, vecs[i].r, vecs[i].key, R);

    rst_n = 1'b0; in_valid = 1'b0; in1_valid = 1'b0; in_mode = 1'b0;
    in_l = '0; in_r = '0; in_key = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset ctrl", 96'({in_ready, out_valid, busy, dbg_state}), 96'(5'b10000));
    chk("reset data", {out_l, out_r}, 96'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ROUNDS=1 instance: single RUN cycle, known zero-input result.
    in1_valid = 1'b1;
    @(posedge clk); #1;
    in1_valid = 1'b0;
    chk("r1 run state", 96'({in1_ready, out1_valid, busy1, dbg1_state}), 96'(5'b00101));
    @(posedge clk); #1;
    chk("r1 done state", 96'({in1_ready, out1_valid, busy1, dbg1_state}), 96'(5'b01110));
    chk("r1 zero data", {out1_l, out1_r}, {48'hDB6D_B6DB_6DB6, 48'h0});
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].mode, vecs[i].l, vecs[i].r, vecs[i].key);
      exp_q.push_back(vecs[i].exp);
      collect($sformatf("vec%0d", i), res);
    end

    for (int i = 0; i < 100; i++) begin
      tl = 48'({$urandom(), $urandom()});
      tr = 48'({$urandom(), $urandom()});
      tk = 48'({$urandom(), $urandom()});
      send(1'b0, tl, tr, tk);
      exp_q.push_back(model(1'b0, tl, tr, tk, R));
      collect("rt enc", res);
      send(1'b1, res[95:48], res[47:0], tk);
      exp_q.push_back({tl, tr});
      collect("rt dec", res);
    end

    // Result must hold through a long stall; a pulsed in_valid is ignored.
    send(1'b0, 48'h0123_4567_89AB, 48'hFEDC_BA98_7654, 48'h0F1E_2D3C_4B5A);
    exp_q.push_back(model(1'b0, 48'h0123_4567_89AB, 48'hFEDC_BA98_7654, 48'h0F1E_2D3C_4B5A, R));
    wait_out(lat);
    chk("hold latency", 96'(lat), 96'(R));
    snap = {out_l, out_r};
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin in_valid = 1'b1; in_l = '1; in_mode = 1'b1; end
      if (c == 11) in_valid = 1'b0;
      @(posedge clk); #1;
      if (!out_valid || ({out_l, out_r} !== snap) || in_ready || !busy) bad++;
    end
    chk("hold stable", 96'(bad), 96'(0));
    chk("hold data", snap, exp_q.pop_front());
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    chk("hold release", 96'({in_ready, out_valid, busy, dbg_state}), 96'(5'b10000));

    // Asynchronous reset in the middle of round 7 aborts the block.
    send(1'b1, 48'hAAAA_5555_AAAA, 48'h1234_5678_9ABC, 48'h0F0F_0F0F_0F0F);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort ctrl", 96'({in_ready, out_valid, busy, dbg_state}), 96'(5'b10000));
    chk("abort data", {out_l, out_r}, 96'h0);
    repeat (3) @(posedge clk); #1;
    chk("abort held", 96'({out_valid, busy}), 96'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 48'hCAFE_BABE_0042, 48'h7777_1111_3333, 48'h0246_8ACE_1357);
    exp_q.push_back(model(1'b0, 48'hCAFE_BABE_0042, 48'h7777_1111_3333, 48'h0246_8ACE_1357, R));
    collect("post abort", res);

    // Streaming with in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid = 1'b1;
    t_prev = 0;
    for (int b = 0; b < 4; b++) begin
      tl = {16'(b), 32'hA5A5_0F0F};
      tr = ~tl;
      tk = {tl[23:0], tr[23:0]};
      in_l = tl; in_r = tr; in_key = tk; in_mode = b[0];
      exp_q.push_back(model(b[0], tl, tr, tk, R));
      bnd = 0;
      while (!in_ready && bnd < 100) begin @(posedge clk); #1; bnd++; end
      @(posedge clk); #1;
      t_now = cyc;
      if (b > 0) chk("stream spacing", 96'(t_now - t_prev), 96'(R + 2));
      t_prev = t_now;
      wait_out(lat);
      chk("stream latency", 96'(lat), 96'(R));
      chk("stream data", {out_l, out_r}, exp_q.pop_front());
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stream idle", 96'({in_ready, out_valid, busy, dbg_state}), 96'(5'b10000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach summary, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
